// File: rtl/branch_pkg.sv
// Shared types and helpers for the VLIW front-end fetch sequencer.
package branch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  localparam int BUNDLE_BYTES_DEFAULT = 16;

  // Clears the low log2(bytes) bits; bytes must be a power of two.
  function automatic logic [31:0] pc_align(input logic [31:0] addr, input int unsigned bytes);
    logic [31:0] mask;
    mask = 32'(bytes) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/branch_fetch_buf.sv
// One-entry holding register for the bundle presented to decode.
// Load wins over clear; with neither asserted the contents are held.
module branch_fetch_buf #(
  parameter int W = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [W-1:0]  i_data,
  input  logic [31:0]   i_pc,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [31:0]   o_pc
);

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [31:0]   r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/branch_fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, bundle to decode after imem latency + 1, redirect/squash on taken branch.
// Optional BRANCH_FETCH_ALIGN_CHK_EN flags misaligned redirect targets on a sticky align_fault.
module branch_fetch_ctrl
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BUNDLE_BYTES = BUNDLE_BYTES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [31:0]               new_pc,
  output logic                      imem_req_valid,
  output logic [31:0]               imem_req_addr,
  input  logic                      imem_req_ready,
  input  logic                      imem_rsp_valid,
  input  logic [BUNDLE_BYTES*8-1:0] imem_rsp_data,
  output logic                      bundle_valid,
  output logic [BUNDLE_BYTES*8-1:0] bundle,
  output logic [31:0]               bundle_pc,
  output logic                      squash,
  output logic                      align_fault
);

  localparam logic [1:0]  ST_BOOT = BOOT;
  localparam logic [1:0]  ST_REQ  = REQ;
  localparam logic [1:0]  ST_WAIT = WAIT_RSP;
  localparam logic [1:0]  ST_HOLD = HOLD;
  localparam logic [31:0] LP_STEP = 32'(BUNDLE_BYTES);
  localparam logic [31:0] LP_MASK = LP_STEP - 32'd1;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_drop;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_drop_nxt;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_capture;

  // A stalled branch is re-presented by the branch pipe, so only act on it once stall drops.
  assign w_redirect = branch_taken & ~stall;
  assign w_target   = pc_align(new_pc, BUNDLE_BYTES);
  assign w_capture  = (r_state == ST_WAIT) & imem_rsp_valid & ~r_drop & ~w_redirect;

  assign squash         = w_redirect;
  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) begin
          w_state_nxt = ST_WAIT;
          w_pc_nxt    = r_pc + LP_STEP;
          w_drop_nxt  = w_redirect;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = (w_capture && stall) ? ST_HOLD : ST_REQ;
        end else if (w_redirect) begin
          w_drop_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_redirect) w_pc_nxt = w_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // r_pc already points past the captured bundle, hence the step back.
  branch_fetch_buf #(
    .W (BUNDLE_BYTES*8)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_capture),
    .i_clear (~stall),
    .i_data  (imem_rsp_data),
    .i_pc    (r_pc - LP_STEP),
    .o_valid (bundle_valid),
    .o_data  (bundle),
    .o_pc    (bundle_pc)
  );

`ifdef BRANCH_FETCH_ALIGN_CHK_EN
  logic r_align_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_fault <= 1'b0;
    end else if (w_redirect && ((new_pc & LP_MASK) != 32'd0)) begin
      r_align_fault <= 1'b1;
    end
  end

  assign align_fault = r_align_fault;
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Bench for branch_fetch_ctrl: directed vector table, reset corner sequence, then random traffic vs a transaction model.
module tb_branch_fetch_ctrl;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          branch_taken;
  logic [31:0]   new_pc;
  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [127:0]  imem_rsp_data;
  logic          bundle_valid;
  logic [127:0]  bundle;
  logic [31:0]   bundle_pc;
  logic          squash;
  logic          align_fault;

`ifdef BRANCH_FETCH_ALIGN_CHK_EN
  localparam logic AF_EN = 1'b1;
`else
  localparam logic AF_EN = 1'b0;
`endif

  int n_checks;
  int n_errors;

  branch_fetch_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .BUNDLE_BYTES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .new_pc         (new_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .bundle_valid   (bundle_valid),
    .bundle         (bundle),
    .bundle_pc      (bundle_pc),
    .squash         (squash),
    .align_fault    (align_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          stall;
    logic          bt;
    logic [31:0]   npc;
    logic          rdy;
    logic          rv;
    logic [127:0]  dat;
    logic          e_rv;
    logic [31:0]   e_addr;
    logic          e_bv;
    logic [31:0]   e_bpc;
    logic [127:0]  e_bundle;
    logic          e_sq;
    logic          e_af;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic bt, input logic [31:0] npc,
                              input logic rdy, input logic rv, input logic [127:0] dat,
                              input logic e_rv, input logic [31:0] e_addr, input logic e_bv,
                              input logic [31:0] e_bpc, input logic [127:0] e_bundle,
                              input logic e_sq, input logic e_af);
    vec_t v;
    v.stall = s; v.bt = bt; v.npc = npc; v.rdy = rdy; v.rv = rv; v.dat = dat;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_bv = e_bv; v.e_bpc = e_bpc;
    v.e_bundle = e_bundle; v.e_sq = e_sq; v.e_af = e_af;
    return v;
  endfunction

  task automatic apply_inputs(input logic s, input logic bt, input logic [31:0] npc,
                              input logic rdy, input logic rv, input logic [127:0] dat);
    stall = s; branch_taken = bt; new_pc = npc;
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = dat;
  endtask

  // Transaction-level reference state
  logic          m_boot, m_out, m_stale, m_hold, m_bv, m_af;
  logic [31:0]   m_pc, m_raddr, m_bpc;
  logic [127:0]  m_bundle;

  logic [127:0]  D0, D1, D2, D3, D4, DX, DY, DZ;
  vec_t          vt[26];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    apply_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0);

    D0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_0000;
    D1 = 128'hA1A1_0000_1111_2222_3333_4444_5555_0001;
    D2 = 128'hA2A2_0000_1111_2222_3333_4444_5555_0002;
    D3 = 128'hA3A3_0000_1111_2222_3333_4444_5555_0003;
    D4 = 128'hA4A4_0000_1111_2222_3333_4444_5555_0004;
    DX = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00AA;
    DY = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00BB;
    DZ = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00CC;

    //          st  bt  npc         rdy rv  dat      e_rv e_addr     e_bv e_bpc     e_bundle e_sq e_af
    vt[0]  = mk(0,  0,  32'h0,      1,  0,  128'd0,  0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[1]  = mk(0,  0,  32'h0,      1,  0,  128'd0,  1,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[2]  = mk(0,  0,  32'h0,      1,  1,  D0,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[3]  = mk(0,  0,  32'h0,      1,  0,  128'd0,  1,   32'h10,    1,   32'h0,    D0,      0,   0);
    vt[4]  = mk(0,  0,  32'h0,      1,  1,  D1,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[5]  = mk(0,  0,  32'h0,      1,  0,  128'd0,  1,   32'h20,    1,   32'h10,   D1,      0,   0);
    vt[6]  = mk(0,  0,  32'h0,      1,  1,  D2,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[7]  = mk(0,  0,  32'h0,      1,  0,  128'd0,  1,   32'h30,    1,   32'h20,   D2,      0,   0);
    vt[8]  = mk(0,  1,  32'h100,    1,  0,  128'd0,  0,   32'h0,     0,   32'h0,    128'd0,  1,   0);
    vt[9]  = mk(0,  0,  32'h0,      1,  1,  DX,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[10] = mk(0,  1,  32'h200,    1,  0,  128'd0,  1,   32'h100,   0,   32'h0,    128'd0,  1,   0);
    vt[11] = mk(0,  0,  32'h0,      1,  1,  DY,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[12] = mk(0,  0,  32'h0,      1,  0,  128'd0,  1,   32'h200,   0,   32'h0,    128'd0,  0,   0);
    vt[13] = mk(0,  0,  32'h0,      1,  1,  D3,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[14] = mk(0,  0,  32'h0,      0,  0,  128'd0,  1,   32'h210,   1,   32'h200,  D3,      0,   0);
    vt[15] = mk(0,  0,  32'h0,      1,  0,  128'd0,  1,   32'h210,   0,   32'h0,    128'd0,  0,   0);
    vt[16] = mk(1,  0,  32'h0,      1,  1,  D4,      0,   32'h0,     0,   32'h0,    128'd0,  0,   0);
    vt[17] = mk(1,  0,  32'h0,      1,  0,  128'd0,  0,   32'h0,     1,   32'h210,  D4,      0,   0);
    vt[18] = mk(1,  1,  32'h300,    1,  0,  128'd0,  0,   32'h0,     1,   32'h210,  D4,      0,   0);
    vt[19] = mk(1,  0,  32'h0,      1,  0,  128'd0,  0,   32'h0,     1,   32'h210,  D4,      0,   0);
    vt[20] = mk(0,  0,  32'h0,      1,  0,  128'd0,  0,   32'h0,     1,   32'h210,  D4,      0,   0);
    vt[21] = mk(1,  1,  32'h300,    0,  0,  128'd0,  1,   32'h220,   0,   32'h0,    128'd0,  0,   0);
    vt[22] = mk(0,  1,  32'h300,    0,  0,  128'd0,  1,   32'h220,   0,   32'h0,    128'd0,  1,   0);
    vt[23] = mk(0,  1,  32'h104,    0,  0,  128'd0,  1,   32'h300,   0,   32'h0,    128'd0,  1,   0);
    vt[24] = mk(0,  0,  32'h0,      0,  0,  128'd0,  1,   32'h100,   0,   32'h0,    128'd0,  0,   AF_EN);
    vt[25] = mk(0,  0,  32'h0,      0,  0,  128'd0,  1,   32'h100,   0,   32'h0,    128'd0,  0,   AF_EN);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_valid", 128'(imem_req_valid), 128'(1'b0));
    chk("reset_bundle_valid", 128'(bundle_valid), 128'(1'b0));
    chk("reset_req_addr", 128'(imem_req_addr), 128'(32'h0));
    chk("reset_align_fault", 128'(align_fault), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply_inputs(vt[i].stall, vt[i].bt, vt[i].npc, vt[i].rdy, vt[i].rv, vt[i].dat);
      #1;
      chk($sformatf("vec%0d_req_valid", i), 128'(imem_req_valid), 128'(vt[i].e_rv));
      if (vt[i].e_rv) chk($sformatf("vec%0d_req_addr", i), 128'(imem_req_addr), 128'(vt[i].e_addr));
      chk($sformatf("vec%0d_bundle_valid", i), 128'(bundle_valid), 128'(vt[i].e_bv));
      if (vt[i].e_bv) begin
        chk($sformatf("vec%0d_bundle_pc", i), 128'(bundle_pc), 128'(vt[i].e_bpc));
        chk($sformatf("vec%0d_bundle", i), bundle, vt[i].e_bundle);
      end
      chk($sformatf("vec%0d_squash", i), 128'(squash), 128'(vt[i].e_sq));
      chk($sformatf("vec%0d_align_fault", i), 128'(align_fault), 128'(vt[i].e_af));
      @(negedge clk);
    end

    // Reset in the middle of an outstanding fetch, then a stray response lands in BOOT.
    apply_inputs(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 128'd0);
    @(negedge clk);
    apply_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 128'(imem_req_valid), 128'(1'b0));
    chk("midrst_req_addr", 128'(imem_req_addr), 128'(32'h0));
    chk("midrst_align_fault", 128'(align_fault), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    apply_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, DZ);
    #1;
    chk("boot_req_valid", 128'(imem_req_valid), 128'(1'b0));
    @(negedge clk);
    apply_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0);
    #1;
    chk("post_boot_req_valid", 128'(imem_req_valid), 128'(1'b1));
    chk("post_boot_req_addr", 128'(imem_req_addr), 128'(32'h0));
    chk("stray_not_captured", 128'(bundle_valid), 128'(1'b0));
    @(negedge clk);
    #1;
    chk("stray_still_dropped", 128'(bundle_valid), 128'(1'b0));

    // Random traffic against the transaction model.
    @(negedge clk);
    rst_n = 1'b0;
    apply_inputs(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_bv = 1'b0; m_af = 1'b0;
    m_pc = 32'h0; m_raddr = 32'h0; m_bpc = 32'h0; m_bundle = 128'd0;
    begin
      logic        pend;
      int          cnt;
      logic        s, bt, rdy, rv, e_rv, redirect, acc, rsp, good, out0;
      logic [31:0] npc;
      logic [127:0] dat;
      pend = 1'b0;
      cnt  = 0;
      for (int c = 0; c < 3000; c++) begin
        s   = ($urandom % 4) == 0;
        bt  = ($urandom % 6) == 0;
        npc = $urandom;
        if (($urandom % 8) != 0) npc[3:0] = 4'h0;
        rdy = ($urandom % 3) != 0;
        rv  = pend && (cnt == 0);
        dat = {$urandom, $urandom, $urandom, $urandom};
        apply_inputs(s, bt, npc, rdy, rv, dat);
        #1;
        e_rv = !m_boot && !m_out && !m_hold;
        redirect = bt && !s;
        chk("rnd_req_valid", 128'(imem_req_valid), 128'(e_rv));
        if (e_rv) chk("rnd_req_addr", 128'(imem_req_addr), 128'(m_pc));
        chk("rnd_bundle_valid", 128'(bundle_valid), 128'(m_bv));
        if (m_bv) begin
          chk("rnd_bundle_pc", 128'(bundle_pc), 128'(m_bpc));
          chk("rnd_bundle", bundle, m_bundle);
        end
        chk("rnd_squash", 128'(squash), 128'(redirect));
        chk("rnd_align_fault", 128'(align_fault), 128'(m_af));

        acc  = e_rv && rdy;
        out0 = m_out;
        rsp  = m_out && rv;
        good = rsp && !m_stale && !redirect;
        if (redirect && (npc[3:0] != 4'h0) && AF_EN) m_af = 1'b1;
        if (good) begin
          m_bv = 1'b1; m_bundle = dat; m_bpc = m_raddr;
        end else if (!s) begin
          m_bv = 1'b0;
        end
        if (good && s) m_hold = 1'b1;
        else if (!s) m_hold = 1'b0;
        if (rsp) begin
          m_out = 1'b0; m_stale = 1'b0;
        end
        if (acc) begin
          m_out = 1'b1; m_stale = redirect; m_raddr = m_pc;
        end else if (out0 && !rsp && redirect) begin
          m_stale = 1'b1;
        end
        if (redirect) m_pc = {npc[31:4], 4'h0};
        else if (acc) m_pc = m_pc + 32'd16;
        m_boot = 1'b0;

        if (rv) pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (imem_req_valid && rdy) begin
          pend = 1'b1;
          cnt  = $urandom_range(0, 2);
        end
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
